// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (common with control_unit),
// execute-stage state encoding and the default datapath width.
package alu_pkg;

  localparam int unsigned WIDTH = 8;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_DIV = 3'b110;
  localparam logic [2:0] ALU_CMP = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// {hi_c,lo_c} is the value being written by the final iteration while done_c is high.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned W = alu_pkg::WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done_c,
  output logic [W-1:0] hi_c,
  output logic [W-1:0] lo_c
);

  localparam int unsigned CW = $clog2(W) + 1;

  logic           busy_q, busy_d;
  logic           div_q, div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W:0]     ext;

  // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div
  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    done_c = 1'b0;
    ext    = '0;
    if (start) begin
      busy_d = 1'b1;
      div_d  = is_div;
      cnt_d  = '0;
      opnd_d = is_div ? b : a;
      acc_d  = is_div ? {W'(0), a} : {W'(0), b};
    end else if (busy_q) begin
      if (div_q) begin
        ext = acc_q[2*W-1:W-1];
        if (ext >= {1'b0, opnd_q}) begin
          ext   = ext - {1'b0, opnd_q};
          acc_d = {ext[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
          acc_d = {ext[W-1:0], acc_q[W-2:0], 1'b0};
        end
      end else begin
        ext   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : (W+1)'(0));
        acc_d = {ext, acc_q[W-1:1]};
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(W-1)) begin
        busy_d = 1'b0;
        done_c = 1'b1;
      end
    end
  end

  assign hi_c = acc_d[2*W-1:W];
  assign lo_c = acc_d[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: valid/ready wrapped ALU with single-cycle logic/arith ops
// and an iterative mul/div engine; all outputs registered.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_neg,
  output logic             div_by_zero
);

  alu_state_e       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             neg_q, neg_d;
  logic             dbz_q, dbz_d;

  logic             accept_c;
  logic             start_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic             md_done_c;
  logic [WIDTH-1:0] md_hi_c;
  logic [WIDTH-1:0] md_lo_c;

  assign accept_c = in_valid && in_ready_q;
  assign sum_c    = {1'b0, op_a} + {1'b0, op_b};
  assign diff_c   = {1'b0, op_a} - {1'b0, op_b};

  alu_seq_muldiv #(.W(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_c),
    .is_div (alu_sel == ALU_DIV),
    .a      (op_a),
    .b      (op_b),
    .done_c (md_done_c),
    .hi_c   (md_hi_c),
    .lo_c   (md_lo_c)
  );

  // Next-state, handshake and result/flag capture
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    neg_d       = neg_q;
    dbz_d       = dbz_q;
    start_c     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          sel_d       = alu_sel;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
          result_hi_d = '0;
          carry_d     = 1'b0;
          dbz_d       = 1'b0;
          case (alu_sel)
            ALU_ADD: begin
              result_d = sum_c[WIDTH-1:0];
              carry_d  = sum_c[WIDTH];
            end
            ALU_SUB: begin
              result_d = diff_c[WIDTH-1:0];
              carry_d  = diff_c[WIDTH];
            end
            ALU_AND: result_d = op_a & op_b;
            ALU_OR:  result_d = op_a | op_b;
            ALU_XOR: result_d = op_a ^ op_b;
            ALU_MUL: begin
              start_c     = 1'b1;
              out_valid_d = 1'b0;
              state_d     = ST_CALC;
            end
            ALU_DIV: begin
              if (op_b == '0) begin
                result_d    = '1;
                result_hi_d = op_a;
                dbz_d       = 1'b1;
              end else begin
                start_c     = 1'b1;
                out_valid_d = 1'b0;
                state_d     = ST_CALC;
              end
            end
            default: result_d = '0;
          endcase
          zero_d = (result_d == '0);
          neg_d  = result_d[WIDTH-1];
          if (alu_sel == ALU_CMP) begin
            zero_d  = (op_a == op_b);
            carry_d = diff_c[WIDTH];
            neg_d   = diff_c[WIDTH-1];
          end
        end
      end
      ST_CALC: begin
        if (md_done_c) begin
          result_d    = md_lo_c;
          result_hi_d = md_hi_c;
          neg_d       = md_lo_c[WIDTH-1];
          if (sel_q == ALU_MUL) begin
            carry_d = (md_hi_c != '0);
            zero_d  = (md_hi_c == '0) && (md_lo_c == '0);
          end else begin
            carry_d = 1'b0;
            zero_d  = (md_lo_c == '0);
          end
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= ALU_ADD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      neg_q       <= neg_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign flag_zero   = zero_q;
  assign flag_carry  = carry_q;
  assign flag_neg    = neg_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors covering latency,
// flags, divide-by-zero, back-pressure and mid-operation reset.
module tb_alu_exec_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] alu_sel;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       flag_zero;
  logic       flag_carry;
  logic       flag_neg;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  alu_exec_unit #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_sel     (alu_sel),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .flag_zero   (flag_zero),
    .flag_carry  (flag_carry),
    .flag_neg    (flag_neg),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present a request at a falling edge; it is accepted at the next rising edge.
  // Inputs are scrambled right after acceptance to prove they were latched.
  task automatic accept_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    check_eq("in_ready_before_accept", int'(in_ready), 1);
    in_valid = 1'b1;
    alu_sel  = sel;
    op_a     = a;
    op_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_sel  = 3'b010;
    op_a     = 8'hA5;
    op_b     = 8'h5A;
  endtask

  // Cycles from the accept edge until out_valid is seen, bounded.
  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_eq("out_valid_timeout", int'(out_valid), 1);
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("out_valid_after_pop", int'(out_valid), 0);
    check_eq("in_ready_after_pop", int'(in_ready), 1);
  endtask

  task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input int exp_res, input int exp_hi,
                        input int exp_z, input int exp_c, input int exp_n, input int exp_dbz);
    accept_op(sel, a, b);
    wait_valid(lat);
    check_eq("latency", lat, exp_lat);
    check_eq("result", int'(result), exp_res);
    check_eq("result_hi", int'(result_hi), exp_hi);
    check_eq("flag_zero", int'(flag_zero), exp_z);
    check_eq("flag_carry", int'(flag_carry), exp_c);
    check_eq("flag_neg", int'(flag_neg), exp_n);
    check_eq("div_by_zero", int'(div_by_zero), exp_dbz);
    release_result();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_sel   = 3'b000;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);
    check_eq("rst_result", int'(result), 0);
    check_eq("rst_result_hi", int'(result_hi), 0);
    check_eq("rst_flags", int'({flag_zero, flag_carry, flag_neg, div_by_zero}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    //     sel     a    b    lat res   hi    z  c  n  dbz
    run_op(3'b000, 200, 100, 1,  44,   0,    0, 1, 0, 0);
    run_op(3'b001, 5,   9,   1,  252,  0,    0, 1, 1, 0);
    run_op(3'b101, 255, 255, 9,  8'h01, 8'hFE, 0, 1, 0, 0);
    run_op(3'b101, 0,   37,  9,  0,    0,    1, 0, 0, 0);
    run_op(3'b110, 200, 7,   9,  28,   4,    0, 0, 0, 0);
    run_op(3'b110, 13,  0,   1,  255,  13,   0, 0, 1, 1);
    run_op(3'b111, 7,   7,   1,  0,    0,    1, 0, 0, 0);
    run_op(3'b111, 3,   9,   1,  0,    0,    0, 1, 1, 0);
    run_op(3'b010, 8'hC3, 8'h0F, 1, 8'h03, 0, 0, 0, 0, 0);
    run_op(3'b011, 8'h80, 8'h01, 1, 8'h81, 0, 0, 0, 1, 0);
    run_op(3'b000, 128, 128, 1,  0,    0,    1, 1, 0, 0);
    run_op(3'b101, 16,  16,  9,  0,    1,    0, 1, 0, 0);

    // Back-pressure: hold the xor result while new requests are offered
    accept_op(3'b100, 8'hF0, 8'h3C);
    wait_valid(lat);
    check_eq("bp_latency", lat, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_sel  = 3'b000;
      op_a     = 8'd1;
      op_b     = 8'd1;
      @(posedge clk);
      #1;
      check_eq("bp_out_valid", int'(out_valid), 1);
      check_eq("bp_result", int'(result), 8'hCC);
      check_eq("bp_in_ready", int'(in_ready), 0);
      check_eq("bp_flags", int'({flag_zero, flag_carry, flag_neg, div_by_zero}), 4'b0010);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    check_eq("bp_result_after_pop", int'(result), 8'hCC);

    // Reset in the middle of a multiply
    accept_op(3'b101, 8'd15, 8'd15);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", int'(out_valid), 0);
    check_eq("midrst_in_ready", int'(in_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) check_eq("midrst_stale_valid", int'(out_valid), 0);
    end
    run_op(3'b000, 1, 1, 1, 2, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage sitting directly downstream of control_unit.
- Consumes the 3-bit alu_sel code together with two operands and produces a result plus status flags.
- Single-cycle ops complete in one cycle; multiply and divide run as iterative multi-cycle ops.
- Valid/ready handshake on both input and output sides so the sequencer can stall on back-pressure.

Parameters:
- WIDTH, 8, operand/result width in bits; mul/div iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request; high only in IDLE
- alu_sel  input  3  operation code from control_unit: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 compare
- op_a  input  WIDTH  operand A, unsigned
- op_b  input  WIDTH  operand B, unsigned
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  primary result (sum/diff/logic/mul low/quotient)
- result_hi  output  WIDTH  mul high half / div remainder; 0 otherwise
- flag_zero  output  1  zero flag
- flag_carry  output  1  carry/borrow/overflow flag
- flag_neg  output  1  MSB of primary arithmetic result
- div_by_zero  output  1  divide with op_b==0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; out_valid, result, result_hi, all flags, div_by_zero = 0; in_ready = 1. Reset mid-operation aborts it; no result is ever presented.
- Accept: handshake when in_valid && in_ready at a rising edge. alu_sel, op_a and op_b are latched at acceptance; later input changes are ignored.
- States and transitions:
  - IDLE: accepts a request. Ops 000-100 and 111 go to DONE. Op 110 with op_b==0 goes to DONE. Ops 101 and 110 (op_b!=0) go to CALC.
  - CALC: one iteration per cycle for WIDTH cycles (shift-add multiply / restoring shift-subtract divide), then DONE. in_ready = 0.
  - DONE: out_valid = 1; all outputs held stable until out_ready is high; then IDLE on the next edge. in_ready = 0.
- Latency, accept edge to out_valid high: 1 cycle for single-cycle ops; WIDTH+1 cycles for mul/div.
- Throughput: no overlap. At least one IDLE cycle separates results.
- Arithmetic (all unsigned):
  - add: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum.
  - sub: result = (a-b) mod 2^WIDTH; carry = borrow (a<b).
  - and/or/xor: bitwise; carry = 0.
  - mul: {result_hi,result} = a*b; carry = (result_hi != 0).
  - div: result = a/b, result_hi = a%b; carry = 0.
  - div by zero: result = all ones, result_hi = a, div_by_zero = 1, carry = 0; completes with 1-cycle latency. div_by_zero = 0 for every other op/case.
  - compare: result = 0, result_hi = 0; flag_zero = (a==b); carry = (a<b); neg = MSB of (a-b).
- Flags:
  - flag_zero = primary result == 0, except: mul uses the full 2*WIDTH product; compare uses a==b.
  - flag_neg = MSB of result, except compare as above.
  - result_hi = 0 for all ops other than mul/div.
- All 8 alu_sel codes are defined, so there is no illegal-opcode path.
- in_valid while not in IDLE: ignored, and no side effect.

Decomposition:
- Shared package alu_pkg:
  - localparams ALU_ADD..ALU_CMP (3'b000..3'b111), shared with control_unit.
  - State encoding IDLE/CALC/DONE.
  - WIDTH default.
- One sub-module, alu_seq_muldiv:
  - Inputs: start, is_div, a, b.
  - Runs the WIDTH-cycle iterative multiply/divide and raises done with {hi,lo}.
  - The top level owns the FSM, handshake, single-cycle datapath and flags.

Test Plan:
- add 200,100 -> out_valid 1 cycle after accept; result 44, carry 1, zero 0. sub 5,9 -> result 252, carry 1, neg 1.
- mul 255,255 -> out_valid exactly 9 cycles after accept; result_hi 0xFE, result 0x01, carry 1. mul 0,37 -> 0/0, zero 1.
- div 200,7 -> result 28, result_hi 4, latency 9. div 13,0 -> 1-cycle latency, result 0xFF, result_hi 13, div_by_zero 1.
- cmp 7,7 -> zero 1, carry 0. cmp 3,9 -> zero 0, carry 1, neg 1, result 0.
- Back-pressure: xor 0xF0,0x3C with out_ready low 5 cycles -> result 0xCC, outputs stable, in_ready 0 and new in_valid ignored throughout; IDLE one cycle after out_ready.
- Reset: assert rst_n low 4 cycles into a mul -> out_valid 0 immediately, in_ready 1. Subsequent add 1,1 -> result 2, no stale mul data.
